// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared constants, state enum and weight/ROM helpers for idct_sample
package idct_pkg;

    localparam int COEF_W   = 19;
    localparam int FRAC     = 14;
    localparam int ACC_W    = 38;
    localparam int SAMPLE_W = 8;
    localparam int WGT_W    = 16;
    localparam int ROM_W    = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // 8192 * cos(m*pi/16), rounded; folded onto the first quarter period
    function automatic int cos_q13(input int m);
        int  mm;
        int  r;
        logic neg;
        mm  = m % 32;
        if (mm > 16) mm = 32 - mm;
        neg = 1'b0;
        if (mm > 8) begin
            mm  = 16 - mm;
            neg = 1'b1;
        end
        case (mm)
            0:       r = 8192;
            1:       r = 8035;
            2:       r = 7568;
            3:       r = 6811;
            4:       r = 5793;
            5:       r = 4551;
            6:       r = 3135;
            7:       r = 1598;
            default: r = 0;
        endcase
        return neg ? -r : r;
    endfunction

    // Wk for output index n: 2^14 * (ck/2) * cos((2n+1)k*pi/16)
    function automatic logic signed [WGT_W-1:0] wgt(input int n, input int k);
        int v;
        if (k == 0) v = 5793;
        else        v = cos_q13((2 * n + 1) * k);
        return WGT_W'(v);
    endfunction

    // Sum of the four weights selected by addr; half 0 covers X0..X3, half 1 covers X4..X7
    function automatic logic signed [ROM_W-1:0] rom_entry(input int n, input int half,
                                                          input logic [3:0] addr);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (addr[i]) s = s + int'(wgt(n, half * 4 + i));
        end
        return ROM_W'(s);
    endfunction

endpackage

// File: rtl/idct_sample_rom.sv
// rtl/idct_sample_rom.sv - 16 x 17 registered distributed-arithmetic weight ROM
module idct_rom
    import idct_pkg::*;
#(
    parameter int N    = 0,
    parameter int HALF = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [3:0]              addr,
    output logic signed [ROM_W-1:0] data
);

    // One cycle of lookup latency; output freezes with en low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (en) begin
            data <= rom_entry(N, HALF, addr);
        end
    end

endmodule

// File: rtl/idct_sample.sv
// rtl/idct_sample.sv - bit-serial distributed-arithmetic IDCT for one output sample
module idct_sample #(
    parameter int N      = 0,
    parameter int COEF_W = 19,
    parameter int FRAC   = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     start,
    input  logic signed [COEF_W-1:0] coef0,
    input  logic signed [COEF_W-1:0] coef1,
    input  logic signed [COEF_W-1:0] coef2,
    input  logic signed [COEF_W-1:0] coef3,
    input  logic signed [COEF_W-1:0] coef4,
    input  logic signed [COEF_W-1:0] coef5,
    input  logic signed [COEF_W-1:0] coef6,
    input  logic signed [COEF_W-1:0] coef7,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [7:0]        sample_out
);

    import idct_pkg::*;

    localparam int CNT_W = $clog2(COEF_W);
    localparam logic [CNT_W-1:0]         CNT_TOP  = CNT_W'(COEF_W - 1);
    localparam logic signed [ACC_W-1:0]  RND_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = -(ACC_W'(128));

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [COEF_W-1:0]          coef_in [8];
    logic [COEF_W-1:0]          sr [8];
    logic [3:0]                 addr_a;
    logic [3:0]                 addr_b;
    logic signed [ROM_W-1:0]    rom_a;
    logic signed [ROM_W-1:0]    rom_b;
    logic                       acc_en;
    logic                       acc_sub;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    rom_sum;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    rnd;
    logic signed [7:0]          sat;

    assign coef_in[0] = coef0;
    assign coef_in[1] = coef1;
    assign coef_in[2] = coef2;
    assign coef_in[3] = coef3;
    assign coef_in[4] = coef4;
    assign coef_in[5] = coef5;
    assign coef_in[6] = coef6;
    assign coef_in[7] = coef7;

    // ROM addresses are the current MSBs of the coefficient shift registers
    always_comb begin
        addr_a = '0;
        addr_b = '0;
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = sr[i][COEF_W-1];
            addr_b[i] = sr[i+4][COEF_W-1];
        end
    end

    idct_rom #(.N(N), .HALF(0)) u_rom_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (addr_a),
        .data  (rom_a)
    );

    idct_rom #(.N(N), .HALF(1)) u_rom_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (addr_b),
        .data  (rom_b)
    );

    // Shift-and-add step; the sign-bit partial product is subtracted
    always_comb begin
        rom_sum  = ACC_W'(rom_a) + ACC_W'(rom_b);
        acc_next = acc_sub ? ((acc <<< 1) - rom_sum) : ((acc <<< 1) + rom_sum);
        rnd      = (acc + RND_HALF) >>> FRAC;
        sat      = rnd[7:0];
        if (rnd > SAT_MAX)      sat = 8'h7F;
        else if (rnd < SAT_MIN) sat = 8'h80;
    end

    // Control FSM plus shift registers and accumulator; acc_en/acc_sub trail the ROM by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            sample_out <= '0;
            acc        <= '0;
            acc_en     <= 1'b0;
            acc_sub    <= 1'b0;
            for (int i = 0; i < 8; i++) sr[i] <= '0;
        end else if (en) begin
            out_valid <= 1'b0;
            acc_en    <= (state == ST_RUN);
            acc_sub   <= (state == ST_RUN) && (cnt == CNT_TOP);
            if (acc_en) acc <= acc_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) sr[i] <= coef_in[i];
                        acc   <= '0;
                        cnt   <= CNT_TOP;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < 8; i++) sr[i] <= {sr[i][COEF_W-2:0], 1'b0};
                    if (cnt == '0) state <= ST_DRAIN;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    sample_out <= sat;
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_sample.sv
// tb/tb_idct_sample.sv - self-checking bench for eight idct_sample instances (N = 0..7)
module tb_idct_sample;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               en;
    logic               start;
    logic signed [18:0] coef [8];
    logic [7:0]         busy_v;
    logic [7:0]         ov_v;
    logic signed [7:0]  so_v [8];

    int  n_vec  = 0;
    int  n_miss = 0;
    int  wq [8][8];
    real wr [8][8];
    int  xs [8];
    int  exp_s [8];
    int  exp_f [8];

    for (genvar g = 0; g < 8; g++) begin : g_dut
        idct_sample #(.N(g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .start      (start),
            .coef0      (coef[0]),
            .coef1      (coef[1]),
            .coef2      (coef[2]),
            .coef3      (coef[3]),
            .coef4      (coef[4]),
            .coef5      (coef[5]),
            .coef6      (coef[6]),
            .coef7      (coef[7]),
            .busy       (busy_v[g]),
            .out_valid  (ov_v[g]),
            .sample_out (so_v[g])
        );
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd_real(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Exact dot product with quantised weights, then round-half-up and clamp
    function automatic int ref_int(input int n);
        longint s;
        longint r;
        s = 0;
        for (int k = 0; k < 8; k++) s = s + longint'(wq[n][k]) * longint'(xs[k]);
        r = (s + 64'sd8192) >>> 14;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Floating-point IDCT with ideal weights
    function automatic int ref_flt(input int n);
        real y;
        y = 0.0;
        for (int k = 0; k < 8; k++) y = y + wr[n][k] * xs[k];
        if (y > 127.0)  y = 127.0;
        if (y < -128.0) y = -128.0;
        return rnd_real(y);
    endfunction

    task automatic compute_exp();
        for (int n = 0; n < 8; n++) begin
            exp_s[n] = ref_int(n);
            exp_f[n] = ref_flt(n);
        end
    endtask

    task automatic load();
        for (int k = 0; k < 8; k++) coef[k] = 19'(xs[k]);
    endtask

    task automatic set_x(input int x0, input int x1);
        for (int k = 0; k < 8; k++) xs[k] = 0;
        xs[0] = x0;
        xs[1] = x1;
    endtask

    task automatic rand_full();
        logic [18:0] t;
        for (int k = 0; k < 8; k++) begin
            t     = 19'($urandom);
            xs[k] = int'($signed(t));
        end
    endtask

    task automatic rand_small();
        for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 2000)) - 1000;
    endtask

    task automatic kick();
        @(negedge clk);
        load();
        compute_exp();
        start = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts enabled edges until out_valid is seen; lat = -1 on timeout
    task automatic wait_result(input bit rnd_en, output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk);
            if (en) lat++;
            @(negedge clk);
            if (ov_v[0]) seen = 1'b1;
            else if (rnd_en) en = ($urandom_range(0, 2) != 0);
        end
        if (!seen) lat = -1;
        en = 1'b1;
    endtask

    task automatic check_samples(input string tag, input bit flt);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("%s_n%0d", tag, n), so_v[n], exp_s[n]);
            if (flt) begin
                int d;
                d = int'(so_v[n]) - exp_f[n];
                chk($sformatf("%s_flt_n%0d", tag, n), (d <= 1 && d >= -1), 1);
            end
        end
        chk({tag, "_ov"}, ov_v, 8'hFF);
        chk({tag, "_busy"}, busy_v, 8'h00);
    endtask

    task automatic run_block(input string tag, input bit rnd_en, input bit flt);
        int lat;
        kick();
        chk({tag, "_busy_start"}, busy_v, 8'hFF);
        wait_result(rnd_en, lat);
        chk({tag, "_lat"}, lat, 21);
        check_samples(tag, flt);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse_end"}, ov_v, 8'h00);
    endtask

    initial begin
        int lat;
        int seen;

        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) begin
                wr[n][k] = ((k == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0
                         * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0);
                wq[n][k] = rnd_real(16384.0 * wr[n][k]);
            end
        end

        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            xs[k]   = 0;
            coef[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_v, 8'h00);
        chk("rst_ov", ov_v, 8'h00);
        for (int n = 0; n < 8; n++) chk($sformatf("rst_sample_n%0d", n), so_v[n], 0);
        rst_n = 1'b1;
        en    = 1'b1;

        set_x(0, 0);
        run_block("zero", 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) chk($sformatf("zero_const_n%0d", n), so_v[n], 0);

        set_x(64, 0);
        run_block("x0_p64", 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) chk($sformatf("x0_p64_const_n%0d", n), so_v[n], 23);

        set_x(-64, 0);
        run_block("x0_m64", 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) chk($sformatf("x0_m64_const_n%0d", n), so_v[n], -23);

        set_x(0, 100);
        run_block("x1_100", 1'b0, 1'b1);
        chk("x1_100_const_n0", so_v[0], 49);

        set_x(1000, 0);
        run_block("x0_p1000", 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) chk($sformatf("x0_p1000_const_n%0d", n), so_v[n], 127);

        set_x(-1000, 0);
        run_block("x0_m1000", 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) chk($sformatf("x0_m1000_const_n%0d", n), so_v[n], -128);

        set_x(-262144, 0);
        run_block("x0_min", 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) chk($sformatf("x0_min_const_n%0d", n), so_v[n], -128);

        for (int k = 0; k < 8; k++) xs[k] = -262144;
        run_block("all_min", 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rand_full();
            run_block($sformatf("rfull%0d", i), 1'b0, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            rand_small();
            run_block($sformatf("rsmall%0d", i), (i % 2) == 1, 1'b1);
        end

        // start pulsed mid-run with different coefficients must be ignored
        rand_small();
        kick();
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rand_small();
        load();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_result(1'b0, lat);
        chk("midstart_lat", lat, 15);
        check_samples("midstart", 1'b0);

        // back-to-back: start on the out_valid cycle
        rand_full();
        load();
        compute_exp();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_ov_drop", ov_v, 8'h00);
        chk("b2b_busy", busy_v, 8'hFF);
        wait_result(1'b0, lat);
        chk("b2b_lat", lat, 21);
        check_samples("b2b", 1'b0);

        // same block with en toggling: same result, same enabled-edge latency
        run_block("en_rand_ref", 1'b0, 1'b0);
        run_block("en_rand", 1'b1, 1'b0);

        // asynchronous reset mid-run
        set_x(500, -300);
        kick();
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_v, 8'h00);
        chk("abort_ov", ov_v, 8'h00);
        for (int n = 0; n < 8; n++) chk($sformatf("abort_sample_n%0d", n), so_v[n], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (ov_v != 8'h00) seen++;
        end
        chk("abort_no_ov", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/idct_sample.md
# idct_sample

Reconstructs one 8-bit EEG sample x[N] from a block of eight signed 19-bit DCT coefficients using bit-serial distributed arithmetic. It is the decode-side counterpart of the per-coefficient DCT units. Eight instances with N = 0..7 rebuild a full 8-sample block. The decoder datapath places it after the RLE expander, and it returns samples in the same signed 8-bit format the DCT units consume.

## Interface
- N, 0, output sample index 0..7 that this instance computes; selects ROM contents
- COEF_W, 19, coefficient width; equals the DCT coefficient output width
- FRAC, 14, fractional bits of ROM weights
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; low freezes all state, including ROM output registers
- start  in  1  one-cycle request; coefficients are sampled on the same edge
- coef0..coef7  in  19 each  signed DCT coefficients X0..X7
- busy  out  1  high from the edge after start is accepted until out_valid
- out_valid  out  1  one-cycle pulse; sample_out is new
- sample_out  out  8  signed reconstructed sample; holds value between pulses

## Operation
- Weight definition: Wk = round(2^14 · (ck/2) · cos((2N+1)kπ/16)), with c0 = 1/√2 and ck = 1 for k > 0. Weights are signed 16-bit.
- ROM_A is addressed by {bit of X3, X2, X1, X0}. ROM_B is addressed by {bit of X7..X4}. Each ROM has 16 entries, and each entry is the sum of the Wk whose address bit is 1. Entries are signed 17-bit.
- Bits are processed MSB-first, from bit 18 down to bit 0, using eight 19-bit shift registers loaded at start.
- Accumulator is 38-bit signed and is cleared at start. Each step computes acc ← (acc <<< 1) ± (ROM_A + ROM_B). The sign-bit step (bit 18) subtracts; all other steps add.
- Final result: sample_out ← sat8((acc + 2^13) >>> 14). Saturation range is [-128, 127].
- FSM states:
  - IDLE: start && en → RUN, with bit counter = 18.
  - RUN: counter decrements to 0, then → DRAIN.
  - DRAIN: performs the last accumulate (this covers the ROM register latency), then → DONE.
  - DONE: registers sample_out and pulses out_valid, then → IDLE.
- Reset values: state IDLE, busy 0, out_valid 0, sample_out 0, acc 0, shift registers 0, ROM registers 0.

## Timing
- ROMs are registered, with one cycle of latency. The ROM registers honour en.
- Latency: out_valid is high in the cycle after the 21st enabled edge following the edge that accepted start.
- Throughput: one sample per 22 enabled cycles. A start coincident with out_valid is accepted, so blocks run back-to-back with no gap.
- start while busy is ignored. The in-flight result and the held coefficients are unaffected.
- With en low, start is not sampled and all counters, registers and out_valid hold. A pending out_valid pulse extends until the next enabled edge.
- rst_n low mid-operation aborts immediately and discards the partial result. No out_valid follows reset release until a new start arrives.
- Coefficient −2^18 must be handled exactly by the sign-bit subtract, with no overflow: |acc| < 2^37.

## Structure
- Shared package idct_pkg holds:
  - COEF_W, FRAC, ACC_W = 38, SAMPLE_W = 8
  - the state enum
  - a constant function wgt(N, k) returning Wk
  - a function rom_entry(N, half, addr)
- Sub-module idct_rom: 16×17 registered ROM with ports clk, rst_n, en, addr[3:0], data. Parameters are N and HALF (0 for A, 1 for B). It is instantiated twice.
- The top level contains the FSM, shift registers, accumulator and round/saturate stage.

## Test plan
- All coefficients 0, start → out_valid after 22 cycles, sample_out = 0 for every N.
- X0 = 64, others 0 → sample_out = 23 for all N. X0 = −64 → −23.
- N = 0, X1 = 100, others 0 → sample_out = 49. X0 = 1000 → 127 (saturated). X0 = −1000 → −128. X0 = −262144 → −128.
- Random coefficient blocks for all eight N, compared against a floating-point IDCT reference model: error ≤ 1 LSB, plus a round-trip check against the DCT units on random 8-bit input blocks.
- start pulsed again mid-RUN with different coefficients → ignored, first result unchanged. start on the out_valid cycle → second result 22 cycles later.
- Inputs:
  - en toggled pseudo-randomly during RUN → result and enabled-cycle latency match the en-always-high run.
  - rst_n asserted at cycle 10 → busy = 0, out_valid = 0, sample_out = 0 immediately, and no spurious out_valid afterwards.
